// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcode/funct
// values and the mux-select / ALU-operation codes seen by the datapath.
package multicycle_ctrl_pkg;

   typedef enum logic [4:0] {
      S_RESET    = 5'd0,
      S_FETCH    = 5'd1,
      S_WAIT     = 5'd2,
      S_IR_LOAD  = 5'd3,
      S_DECODE   = 5'd4,
      S_EXEC_R   = 5'd5,
      S_WB_R     = 5'd6,
      S_EXEC_I   = 5'd7,
      S_WB_I     = 5'd8,
      S_MEM_ADDR = 5'd9,
      S_LD_WAIT  = 5'd10,
      S_LD_MDR   = 5'd11,
      S_LD_WB    = 5'd12,
      S_STORE    = 5'd13,
      S_BRANCH   = 5'd14,
      S_JUMP     = 5'd15,
      S_EXC      = 5'd16,
      S_EXC_WAIT = 5'd17,
      S_EXC_JMP  = 5'd18
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;

   localparam logic [2:0] ALU_PASS = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;
   localparam logic [2:0] ALU_AND  = 3'd3;

   localparam logic [1:0] ASA_PC = 2'd0;
   localparam logic [1:0] ASA_A  = 2'd1;

   localparam logic [2:0] ASB_B      = 3'd0;
   localparam logic [2:0] ASB_FOUR   = 3'd1;
   localparam logic [2:0] ASB_IMM    = 3'd3;
   localparam logic [2:0] ASB_IMM_SH = 3'd4;

   localparam logic [2:0] PCS_ALU    = 3'd0;
   localparam logic [2:0] PCS_ALUOUT = 3'd1;
   localparam logic [2:0] PCS_JUMP   = 3'd2;
   localparam logic [2:0] PCS_VEC    = 3'd3;

   localparam logic [2:0] IORD_PC     = 3'd0;
   localparam logic [2:0] IORD_ALUOUT = 3'd1;
   localparam logic [2:0] IORD_VEC    = 3'd2;

   localparam logic [2:0] M2R_ALUOUT = 3'd0;
   localparam logic [2:0] M2R_MDR    = 3'd1;
   localparam logic [2:0] M2R_SP     = 3'd3;

   localparam logic [1:0] RDST_RT = 2'd0;
   localparam logic [1:0] RDST_SP = 2'd1;
   localparam logic [1:0] RDST_RD = 2'd3;

   localparam logic [1:0] CAUSE_NONE = 2'd0;
   localparam logic [1:0] CAUSE_OVF  = 2'd1;
   localparam logic [1:0] CAUSE_OPC  = 2'd2;

   function automatic logic funct_ok(input logic [5:0] f);
      return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND);
   endfunction

   function automatic logic [2:0] funct_alu(input logic [5:0] f);
      case (f)
         FN_ADD:  return ALU_ADD;
         FN_SUB:  return ALU_SUB;
         FN_AND:  return ALU_AND;
         default: return ALU_PASS;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: ALU/IR status in, write enables and selects out.
interface multicycle_ctrl_if;
   import multicycle_ctrl_pkg::*;

   logic       overflow;
   logic       igual;
   logic [5:0] opcode;
   logic [5:0] funct;

   logic       PC_write;
   logic       MEMWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic       A_write;
   logic       B_write;
   logic       MDR_load;
   logic       EPCWrite;
   logic       AluOutWrite;
   logic [1:0] RegDst;
   logic [1:0] ALUSourceA;
   logic [2:0] IorD;
   logic [2:0] MemToReg;
   logic [2:0] ALUSourceB;
   logic [2:0] AluOp;
   logic [2:0] PCSource;
   logic [4:0] state_o;
   logic [1:0] exc_cause;

   modport master (
      input  overflow, igual, opcode, funct,
      output PC_write, MEMWrite, IRWrite, RegWrite, A_write, B_write,
             MDR_load, EPCWrite, AluOutWrite, RegDst, ALUSourceA, IorD,
             MemToReg, ALUSourceB, AluOp, PCSource, state_o, exc_cause
   );

   modport slave (
      output overflow, igual, opcode, funct,
      input  PC_write, MEMWrite, IRWrite, RegWrite, A_write, B_write,
             MDR_load, EPCWrite, AluOutWrite, RegDst, ALUSourceA, IorD,
             MemToReg, ALUSourceB, AluOp, PCSource, state_o, exc_cause
   );

endinterface

// File: rtl/multicycle_ctrl_wait_counter.sv
// Memory-latency down counter: load sets the cycle count, dec counts down and
// saturates at zero; done flags the last cycle of a wait (count <= 1).
module mc_wait_counter (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [2:0] load_val,
   input  logic       dec,
   output logic       done
);

   logic [2:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= 3'd0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != 3'd0)) begin
         cnt <= cnt - 3'd1;
      end
   end

   assign done = (cnt <= 3'd1);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM; Moore outputs (PC_write in BRANCH follows
// igual combinationally), memory waits sized by MEM_WAIT, traps via EXC path.
module multicycle_ctrl #(
   parameter int MEM_WAIT = 2,
   parameter int OVF_TRAP = 1
) (
   input logic              clk,
   input logic              reset,
   multicycle_ctrl_if.master bus
);
   import multicycle_ctrl_pkg::*;

   localparam logic [2:0] WAIT_LD = 3'(MEM_WAIT - 1);
   localparam logic [2:0] EXC_LD  = 3'(MEM_WAIT);

   state_t     state, state_nxt;
   logic [1:0] cause_r, cause_nxt;
   logic [2:0] alu_r;
   logic       ovf_chk_r, store_r, br_ne_r;
   logic       cnt_load, cnt_dec, cnt_done;
   logic [2:0] cnt_val;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_RESET;
         cause_r <= CAUSE_NONE;
      end else begin
         state   <= state_nxt;
         cause_r <= cause_nxt;
      end
   end

   // Instruction attributes captured at DECODE so later states stay Moore
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_r     <= ALU_PASS;
         ovf_chk_r <= 1'b0;
         store_r   <= 1'b0;
         br_ne_r   <= 1'b0;
      end else if (state == S_DECODE) begin
         alu_r     <= funct_alu(bus.funct);
         ovf_chk_r <= (bus.funct == FN_ADD) || (bus.funct == FN_SUB);
         store_r   <= (bus.opcode == OP_SW);
         br_ne_r   <= (bus.opcode == OP_BNE);
      end
   end

   assign cnt_dec = (state == S_WAIT) || (state == S_LD_WAIT) || (state == S_EXC_WAIT);

   mc_wait_counter u_wait (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .done     (cnt_done)
   );

   assign bus.state_o   = state;
   assign bus.exc_cause = cause_r;

   always_comb begin
      state_nxt       = state;
      cause_nxt       = cause_r;
      cnt_load        = 1'b0;
      cnt_val         = 3'd0;
      bus.PC_write    = 1'b0;
      bus.MEMWrite    = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.A_write     = 1'b0;
      bus.B_write     = 1'b0;
      bus.MDR_load    = 1'b0;
      bus.EPCWrite    = 1'b0;
      bus.AluOutWrite = 1'b0;
      bus.RegDst      = 2'd0;
      bus.ALUSourceA  = 2'd0;
      bus.IorD        = 3'd0;
      bus.MemToReg    = 3'd0;
      bus.ALUSourceB  = 3'd0;
      bus.AluOp       = 3'd0;
      bus.PCSource    = 3'd0;

      case (state)
         S_RESET: begin
            bus.RegWrite = 1'b1;
            bus.RegDst   = RDST_SP;
            bus.MemToReg = M2R_SP;
            state_nxt    = S_FETCH;
         end
         S_FETCH: begin
            bus.PC_write   = 1'b1;
            bus.ALUSourceA = ASA_PC;
            bus.ALUSourceB = ASB_FOUR;
            bus.AluOp      = ALU_ADD;
            bus.PCSource   = PCS_ALU;
            bus.IorD       = IORD_PC;
            if (MEM_WAIT == 1) begin
               state_nxt = S_IR_LOAD;
            end else begin
               state_nxt = S_WAIT;
               cnt_load  = 1'b1;
               cnt_val   = WAIT_LD;
            end
         end
         S_WAIT: begin
            if (cnt_done) state_nxt = S_IR_LOAD;
         end
         S_IR_LOAD: begin
            bus.IRWrite = 1'b1;
            state_nxt   = S_DECODE;
         end
         S_DECODE: begin
            bus.A_write     = 1'b1;
            bus.B_write     = 1'b1;
            bus.AluOutWrite = 1'b1;
            bus.ALUSourceA  = ASA_PC;
            bus.ALUSourceB  = ASB_IMM_SH;
            bus.AluOp       = ALU_ADD;
            case (bus.opcode)
               OP_RTYPE:      state_nxt = funct_ok(bus.funct) ? S_EXEC_R : S_EXC;
               OP_ADDI:       state_nxt = S_EXEC_I;
               OP_LW, OP_SW:  state_nxt = S_MEM_ADDR;
               OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
               OP_J:          state_nxt = S_JUMP;
               default:       state_nxt = S_EXC;
            endcase
            if (state_nxt == S_EXC) cause_nxt = CAUSE_OPC;
         end
         S_EXEC_R: begin
            bus.AluOutWrite = 1'b1;
            bus.ALUSourceA  = ASA_A;
            bus.ALUSourceB  = ASB_B;
            bus.AluOp       = alu_r;
            if ((OVF_TRAP != 0) && ovf_chk_r && bus.overflow) begin
               state_nxt = S_EXC;
               cause_nxt = CAUSE_OVF;
            end else begin
               state_nxt = S_WB_R;
            end
         end
         S_WB_R: begin
            bus.RegWrite = 1'b1;
            bus.RegDst   = RDST_RD;
            bus.MemToReg = M2R_ALUOUT;
            state_nxt    = S_FETCH;
         end
         S_EXEC_I: begin
            bus.AluOutWrite = 1'b1;
            bus.ALUSourceA  = ASA_A;
            bus.ALUSourceB  = ASB_IMM;
            bus.AluOp       = ALU_ADD;
            if ((OVF_TRAP != 0) && bus.overflow) begin
               state_nxt = S_EXC;
               cause_nxt = CAUSE_OVF;
            end else begin
               state_nxt = S_WB_I;
            end
         end
         S_WB_I: begin
            bus.RegWrite = 1'b1;
            bus.RegDst   = RDST_RT;
            bus.MemToReg = M2R_ALUOUT;
            state_nxt    = S_FETCH;
         end
         S_MEM_ADDR: begin
            bus.AluOutWrite = 1'b1;
            bus.ALUSourceA  = ASA_A;
            bus.ALUSourceB  = ASB_IMM;
            bus.AluOp       = ALU_ADD;
            if (store_r) begin
               state_nxt = S_STORE;
            end else if (MEM_WAIT == 1) begin
               state_nxt = S_LD_MDR;
            end else begin
               state_nxt = S_LD_WAIT;
               cnt_load  = 1'b1;
               cnt_val   = WAIT_LD;
            end
         end
         S_LD_WAIT: begin
            bus.IorD = IORD_ALUOUT;
            if (cnt_done) state_nxt = S_LD_MDR;
         end
         S_LD_MDR: begin
            bus.MDR_load = 1'b1;
            bus.IorD     = IORD_ALUOUT;
            state_nxt    = S_LD_WB;
         end
         S_LD_WB: begin
            bus.RegWrite = 1'b1;
            bus.RegDst   = RDST_RT;
            bus.MemToReg = M2R_MDR;
            state_nxt    = S_FETCH;
         end
         S_STORE: begin
            bus.MEMWrite = 1'b1;
            bus.IorD     = IORD_ALUOUT;
            state_nxt    = S_FETCH;
         end
         S_BRANCH: begin
            bus.ALUSourceA = ASA_A;
            bus.ALUSourceB = ASB_B;
            bus.AluOp      = ALU_SUB;
            bus.PCSource   = PCS_ALUOUT;
            bus.PC_write   = br_ne_r ? !bus.igual : bus.igual;
            state_nxt      = S_FETCH;
         end
         S_JUMP: begin
            bus.PC_write = 1'b1;
            bus.PCSource = PCS_JUMP;
            state_nxt    = S_FETCH;
         end
         S_EXC: begin
            bus.EPCWrite   = 1'b1;
            bus.ALUSourceA = ASA_PC;
            bus.ALUSourceB = ASB_FOUR;
            bus.AluOp      = ALU_SUB;
            state_nxt      = S_EXC_WAIT;
            cnt_load       = 1'b1;
            cnt_val        = EXC_LD;
         end
         S_EXC_WAIT: begin
            bus.IorD     = IORD_VEC;
            bus.MDR_load = cnt_done;
            if (cnt_done) state_nxt = S_EXC_JMP;
         end
         S_EXC_JMP: begin
            bus.PC_write = 1'b1;
            bus.PCSource = PCS_VEC;
            state_nxt    = S_FETCH;
         end
         default: state_nxt = S_RESET;
      endcase
   end

endmodule
